// File: rtl/prefix_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix subtractor.
// Generate/propagate pairs are carried as packed structs through the Kogge-Stone tree.
package prefix_pkg;

    localparam int PFX_W   = 8;
    localparam int PFX_LAT = 3;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef gp_t [PFX_W-1:0] gp_vec_t;

    // Subtraction runs as a + ~b + ~bin, so the subtrahend is inverted before g/p.
    function automatic gp_vec_t gp_gen(input logic [PFX_W-1:0] a, input logic [PFX_W-1:0] b);
        gp_vec_t v;
        for (int k = 0; k < PFX_W; k++) begin
            v[k].g = a[k] & ~b[k];
            v[k].p = a[k] ^ ~b[k];
        end
        return v;
    endfunction

    function automatic logic [PFX_W-1:0] gp_props(input gp_vec_t v);
        logic [PFX_W-1:0] r;
        for (int k = 0; k < PFX_W; k++) begin
            r[k] = v[k].p;
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: combines a bit group with the adjacent lower group.
module prefix_gp_cell
    import prefix_pkg::*;
(
    input  gp_t cur,
    input  gp_t prev,
    output gp_t res
);

    assign res.g = cur.g | (cur.p & prev.g);
    assign res.p = cur.p & prev.p;

endmodule

// File: rtl/prefix_sub8_pipe.sv
// 3-stage elastic 8-bit prefix subtractor: diff = a - b - bin, with borrow-out.
// Optional signed-overflow output enabled by defining PREFIX_SUB_OVF_EN.
module prefix_sub8_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = PFX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef PREFIX_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LAT = PFX_LAT;

    logic vld_p0, vld_p1, vld_p2;
    logic adv2, adv3;

    gp_vec_t gp_p0;
    logic    c0_p0;
    gp_vec_t grp_p1;
    logic [PFX_W-1:0] prop_p1;
    logic    c0_p1;
`ifdef PREFIX_SUB_OVF_EN
    logic sa_p0, sb_p0, sa_p1, sb_p1;
`endif

    assign adv3      = ~vld_p2 | out_ready;
    assign adv2      = ~vld_p1 | adv3;
    assign in_ready  = ~vld_p0 | adv2;
    assign out_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p0 <= in_valid;
            if (adv2)     vld_p1 <= vld_p0;
            if (adv3)     vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: generate / propagate from a and inverted b ----
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            gp_p0 <= gp_gen(a, b);
            c0_p0 <= ~bin;
`ifdef PREFIX_SUB_OVF_EN
            sa_p0 <= a[WIDTH-1];
            sb_p0 <= b[WIDTH-1];
`endif
        end
    end

    // ---- stage 2: carry-in folded into bit 0, then prefix spans 1 and 2 ----
    gp_vec_t l0, l1, l2, l3;

    always_comb begin
        l0      = gp_p0;
        l0[0].g = gp_p0[0].g | (gp_p0[0].p & c0_p0);
    end

    for (genvar i = 0; i < PFX_W; i++) begin : g_lvl1
        if (i >= 1) begin : g_cell
            prefix_gp_cell u_cell (.cur(l0[i]), .prev(l0[i-1]), .res(l1[i]));
        end else begin : g_pass
            assign l1[i] = l0[i];
        end
    end

    for (genvar i = 0; i < PFX_W; i++) begin : g_lvl2
        if (i >= 2) begin : g_cell
            prefix_gp_cell u_cell (.cur(l1[i]), .prev(l1[i-2]), .res(l2[i]));
        end else begin : g_pass
            assign l2[i] = l1[i];
        end
    end

    always_ff @(posedge clk) begin
        if (adv2 && vld_p0) begin
            grp_p1  <= l2;
            prop_p1 <= gp_props(gp_p0);
            c0_p1   <= c0_p0;
`ifdef PREFIX_SUB_OVF_EN
            sa_p1   <= sa_p0;
            sb_p1   <= sb_p0;
`endif
        end
    end

    // ---- stage 3: span-4 level completes the carries, sum bits registered as outputs ----
    for (genvar i = 0; i < PFX_W; i++) begin : g_lvl3
        if (i >= 4) begin : g_cell
            prefix_gp_cell u_cell (.cur(grp_p1[i]), .prev(grp_p1[i-4]), .res(l3[i]));
        end else begin : g_pass
            assign l3[i] = grp_p1[i];
        end
    end

    logic [PFX_W-1:0] carry;
    logic [PFX_W-1:0] diff_n;

    always_comb begin
        carry  = '0;
        diff_n = '0;
        for (int k = 0; k < PFX_W; k++) begin
            carry[k] = l3[k].g;
        end
        diff_n[0] = prop_p1[0] ^ c0_p1;
        for (int k = 1; k < PFX_W; k++) begin
            diff_n[k] = prop_p1[k] ^ carry[k-1];
        end
    end

    // Group propagates of the last level only matter for wider trees.
    logic unused_tail;
    assign unused_tail = ^{gp_props(l3), LAT[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
`ifdef PREFIX_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (adv3 && vld_p1) begin
            diff <= diff_n;
            bout <= ~carry[PFX_W-1];
`ifdef PREFIX_SUB_OVF_EN
            ovf  <= (sa_p1 ^ sb_p1) & (sa_p1 ^ diff_n[PFX_W-1]);
`endif
        end
    end

endmodule
